// File: rtl/idli_pkg.sv
// ==== idli_pkg : shared SQI responder types, opcodes and sizing =============
// ==== rev 1.0                                                     ===========
`default_nettype none

package idli_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INSTR  = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    READ   = 3'd4,
    WRITE  = 3'd5,
    IGNORE = 3'd6
  } sqi_resp_state_t;

  localparam logic [7:0] SQI_INSTR_READ   = 8'h03;
  localparam logic [7:0] SQI_INSTR_WRITE  = 8'h02;
  localparam int         SQI_ADDR_W       = 16;
  localparam int         SQI_DUMMY_CYCLES = 2;

  function automatic logic [3:0] sqi_nibble(input logic [7:0] b, input logic lo);
    return lo ? b[3:0] : b[7:4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/idli_sqi_resp_mem_m.sv
// ==== idli_sqi_resp_mem_m : byte storage, 1 write port, 1 sync read port ====
// ==== rev 1.0                                                     ===========
`default_nettype none

module idli_sqi_resp_mem_m
  import idli_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [SQI_ADDR_W-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [SQI_ADDR_W-1:0] raddr,
  output logic [7:0]            rdata
);

  logic [7:0] mem [0:(1<<SQI_ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/idli_sqi_resp_m.sv
// ==== idli_sqi_resp_m : SQI memory responder; IDLI_SQI_RESP_WRITE_EN enables ==
// ==== the 0x02 write command (otherwise storage is read-only).  rev 1.0 ======
`default_nettype none

module idli_sqi_resp_m
  import idli_pkg::*;
(
  input  logic            i_resp_gck,
  input  logic            i_resp_rst,
  input  logic            i_resp_sqi_sck,
  input  logic            i_resp_sqi_cs,
  input  logic [3:0]      i_resp_sqi_data,
  output logic [3:0]      o_resp_sqi_data,
  output logic            o_resp_sqi_oe,
  output sqi_resp_state_t o_resp_state
);

`ifdef IDLI_SQI_RESP_WRITE_EN
  localparam logic WRITE_EN = 1'b1;
`else
  localparam logic WRITE_EN = 1'b0;
`endif

  localparam logic [1:0] ADDR_LAST  = 2'(SQI_ADDR_W / 4 - 1);
  localparam logic [1:0] DUMMY_LAST = 2'(SQI_DUMMY_CYCLES - 1);

  sqi_resp_state_t       state, state_d;
  logic                  sck_q, cs_q;
  logic [1:0]            nib_cnt, nib_cnt_d;
  logic [SQI_ADDR_W-1:0] addr, addr_d;
  logic [3:0]            hold, hold_d;
  logic                  is_wr, is_wr_d;
  logic [3:0]            dout, dout_d;
  logic                  oe, oe_d;
  logic                  wr_fire;
  logic                  mem_we;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  sck_rise, sck_fall;

  assign sck_rise  = i_resp_sqi_sck & ~sck_q;
  assign sck_fall  = ~i_resp_sqi_sck & sck_q;
  assign mem_wdata = {hold, i_resp_sqi_data};
  assign mem_we    = WRITE_EN & wr_fire;

  always_ff @(posedge i_resp_gck or posedge i_resp_rst) begin
    if (i_resp_rst) begin
      state   <= IDLE;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      nib_cnt <= 2'd0;
      addr    <= '0;
      hold    <= 4'd0;
      is_wr   <= 1'b0;
      dout    <= 4'd0;
      oe      <= 1'b0;
    end else begin
      state   <= state_d;
      sck_q   <= i_resp_sqi_sck;
      cs_q    <= i_resp_sqi_cs;
      nib_cnt <= nib_cnt_d;
      addr    <= addr_d;
      hold    <= hold_d;
      is_wr   <= is_wr_d;
      dout    <= dout_d;
      oe      <= oe_d;
    end
  end

  always_comb begin
    state_d   = state;
    nib_cnt_d = nib_cnt;
    addr_d    = addr;
    hold_d    = hold;
    is_wr_d   = is_wr;
    dout_d    = dout;
    oe_d      = oe;
    wr_fire   = 1'b0;
    // Deselect overrides everything, including a coincident SCK rise.
    if (i_resp_sqi_cs) begin
      state_d   = IDLE;
      nib_cnt_d = 2'd0;
      dout_d    = 4'd0;
      oe_d      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_q) begin
            state_d   = INSTR;
            nib_cnt_d = 2'd0;
          end
        end
        INSTR: begin
          if (sck_rise) begin
            if (nib_cnt == 2'd0) begin
              hold_d    = i_resp_sqi_data;
              nib_cnt_d = 2'd1;
            end else begin
              nib_cnt_d = 2'd0;
              if ({hold, i_resp_sqi_data} == SQI_INSTR_READ) begin
                state_d = ADDR;
                is_wr_d = 1'b0;
              end else if (WRITE_EN && ({hold, i_resp_sqi_data} == SQI_INSTR_WRITE)) begin
                state_d = ADDR;
                is_wr_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_d = {addr[SQI_ADDR_W-5:0], i_resp_sqi_data};
            if (nib_cnt == ADDR_LAST) begin
              nib_cnt_d = 2'd0;
              state_d   = is_wr ? WRITE : DUMMY;
            end else begin
              nib_cnt_d = nib_cnt + 2'd1;
            end
          end
        end
        DUMMY: begin
          // Storage read port follows addr, so the byte is ready before READ drives it.
          if (sck_rise) begin
            if (nib_cnt == DUMMY_LAST) begin
              nib_cnt_d = 2'd0;
              state_d   = READ;
            end else begin
              nib_cnt_d = nib_cnt + 2'd1;
            end
          end
        end
        READ: begin
          if (sck_fall) begin
            oe_d   = 1'b1;
            dout_d = sqi_nibble(mem_rdata, nib_cnt[0]);
            if (nib_cnt[0]) begin
              nib_cnt_d = 2'd0;
              addr_d    = addr + SQI_ADDR_W'(1);
            end else begin
              nib_cnt_d = 2'd1;
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            if (nib_cnt[0]) begin
              wr_fire   = 1'b1;
              nib_cnt_d = 2'd0;
              addr_d    = addr + SQI_ADDR_W'(1);
            end else begin
              hold_d    = i_resp_sqi_data;
              nib_cnt_d = 2'd1;
            end
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  idli_sqi_resp_mem_m u_mem (
    .clk   (i_resp_gck),
    .we    (mem_we),
    .waddr (addr),
    .wdata (mem_wdata),
    .raddr (addr),
    .rdata (mem_rdata)
  );

  assign o_resp_sqi_data = dout;
  assign o_resp_sqi_oe   = oe;
  assign o_resp_state    = state;

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_resp_m.sv
// ==== tb_idli_sqi_resp_m : transaction-level checks of the SQI responder =====
// ==== rev 1.0                                                     ===========
`default_nettype none

module tb_idli_sqi_resp_m;
  import idli_pkg::*;

`ifdef IDLI_SQI_RESP_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sck = 1'b0;
  logic            cs  = 1'b1;
  logic [3:0]      din = 4'd0;
  logic [3:0]      dout;
  logic            oe;
  sqi_resp_state_t st;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  idli_sqi_resp_m dut (
    .i_resp_gck      (clk),
    .i_resp_rst      (rst),
    .i_resp_sqi_sck  (sck),
    .i_resp_sqi_cs   (cs),
    .i_resp_sqi_data (din),
    .o_resp_sqi_data (dout),
    .o_resp_sqi_oe   (oe),
    .o_resp_state    (st)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SCK period: rise carries the initiator nibble, the fall lets the responder drive.
  task automatic sck_cycle(input logic [3:0] n, output logic [3:0] dq, output logic oq);
    @(negedge clk);
    din = n;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    dq = dout;
    oq = oe;
  endtask

  task automatic send_nib(input logic [3:0] n);
    logic [3:0] d;
    logic       o;
    sck_cycle(n, d, o);
    check("bus_idle", {27'd0, o, d}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    check("cs_fall_state", 32'(st), 32'(INSTR));
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs  = 1'b1;
    din = 4'd0;
    @(negedge clk);
    check("cs_high_state", 32'(st), 32'(IDLE));
    check("cs_high_bus", {27'd0, oe, dout}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic start(input logic [7:0] instr, input logic [15:0] a);
    sqi_resp_state_t e1, e2;
    if (instr == 8'h03) begin
      e1 = ADDR;   e2 = DUMMY;
    end else if (instr == 8'h02 && WR_EN) begin
      e1 = ADDR;   e2 = WRITE;
    end else begin
      e1 = IGNORE; e2 = IGNORE;
    end
    cs_low();
    send_byte(instr);
    check("instr_state", 32'(st), 32'(e1));
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    check("addr_state", 32'(st), 32'(e2));
  endtask

  task automatic read_check(input logic [15:0] a, input int n);
    logic [3:0] d;
    logic       o;
    logic [7:0] b;
    start(8'h03, a);
    sck_cycle(4'($urandom), d, o);
    check("dummy_bus", {27'd0, o, d}, 32'd0);
    for (int k = 0; k < 2 * n; k++) begin
      sck_cycle(4'($urandom), d, o);
      b = ref_mem[16'(a + 16'(k / 2))];
      check("rd_nibble", 32'(d), 32'((k % 2) ? b[3:0] : b[7:4]));
      check("rd_oe", 32'(o), 32'd1);
    end
    cs_high();
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [7:0] q[$]);
    start(8'h02, a);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (WR_EN) ref_mem[16'(a + 16'(i))] = q[i];
    end
    cs_high();
  endtask

  initial begin
    logic [3:0]  d;
    logic        o;
    logic [15:0] a;
    logic [7:0]  wq[$];

    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = 8'($urandom);
    end
    ref_mem[16'h1234] = 8'hA5;
    ref_mem[16'hFFFF] = 8'h11;
    ref_mem[16'h0000] = 8'h22;
    for (int i = 0; i < 65536; i++) begin
      dut.u_mem.mem[i] = ref_mem[i];
    end

    repeat (3) @(negedge clk);
    check("rst_state", 32'(st), 32'(IDLE));
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_data", 32'(dout), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    read_check(16'h1234, 1);
    read_check(16'hFFFF, 2);
    for (int i = 0; i < 4; i++) begin
      read_check(16'($urandom), int'($urandom_range(1, 3)));
    end

    // Unknown opcode: bus stays quiet until deselect, then normal service.
    cs_low();
    send_byte(8'h9F);
    check("ign_state", 32'(st), 32'(IGNORE));
    for (int i = 0; i < 4; i++) send_nib(4'($urandom));
    check("ign_hold", 32'(st), 32'(IGNORE));
    cs_high();
    read_check(16'h1234, 1);

    wq = {8'h3C, 8'h7E};
    write_txn(16'h0010, wq);
    read_check(16'h0010, 2);

    // Write aborted after the high nibble must leave storage untouched.
    start(8'h02, 16'h0020);
    send_nib(4'($urandom));
    cs_high();
    read_check(16'h0020, 1);

    // Deselect coinciding with the low-nibble rise must not write.
    start(8'h02, 16'h0030);
    send_nib(4'($urandom));
    @(negedge clk);
    din = 4'($urandom);
    sck = 1'b1;
    cs  = 1'b1;
    @(negedge clk);
    check("cs_vs_rise_state", 32'(st), 32'(IDLE));
    repeat (3) @(negedge clk);
    sck = 1'b0;
    repeat (3) @(negedge clk);
    read_check(16'h0030, 1);

    wq = {8'($urandom), 8'($urandom)};
    write_txn(16'hFFFF, wq);
    read_check(16'hFFFE, 4);
    a = 16'($urandom);
    wq = {8'($urandom), 8'($urandom), 8'($urandom)};
    write_txn(a, wq);
    read_check(a, 3);

    // Reset mid-READ aborts at once; storage survives.
    a = 16'($urandom);
    start(8'h03, a);
    sck_cycle(4'($urandom), d, o);
    sck_cycle(4'($urandom), d, o);
    check("pre_rst_nib", 32'(d), 32'(ref_mem[a][7:4]));
    check("pre_rst_oe", 32'(o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    cs  = 1'b1;
    #1;
    check("mid_rst_state", 32'(st), 32'(IDLE));
    check("mid_rst_oe", 32'(oe), 32'd0);
    check("mid_rst_data", 32'(dout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    read_check(a, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/idli_sqi_resp_m.md
IDLI_SQI_RESP_M -- requirements
Module: idli_sqi_resp_m

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 i_resp_gck  in  1  core clock; all state updates on its rising edge.
REQ-003 i_resp_rst  in  1  asynchronous active-high reset.
REQ-004 i_resp_sqi_sck  in  1  SQI serial clock from the initiator, sampled in i_resp_gck domain.
REQ-005 i_resp_sqi_cs  in  1  chip select, active-low.
REQ-006 i_resp_sqi_data  in  4  nibble from the initiator.
REQ-007 o_resp_sqi_data  out  4  nibble to the initiator.
REQ-008 o_resp_sqi_oe  out  1  high when the responder drives o_resp_sqi_data.
REQ-009 o_resp_state  out  sqi_resp_state_t  current FSM state, for debug and checking.

Function
REQ-010 SHALL detect SCK rise as sck_q=0 and sck=1, and SCK fall as sck_q=1 and sck=0, using one registered copy sck_q.
REQ-011 SHALL sample i_resp_sqi_data only in a cycle with SCK rise and cs=0.
REQ-012 SHALL update o_resp_sqi_data and o_resp_sqi_oe only in a cycle with SCK fall; the new value is visible the following gck cycle.
REQ-013 FSM states: IDLE, INSTR, ADDR, DUMMY, READ, WRITE, IGNORE.
REQ-014 IDLE -> INSTR on cs falling (cs=0 with cs_q=1).
REQ-015 INSTR: 2 nibbles, high nibble first; 0x03 -> ADDR(read), 0x02 -> ADDR(write), any other -> IGNORE.
REQ-016 ADDR: 4 nibbles forming a 16-bit address, high nibble first; read -> DUMMY, write -> WRITE.
REQ-017 DUMMY: exactly 2 SCK rises; the byte at the address is fetched on DUMMY entry; DUMMY -> READ after the 2nd rise.
REQ-018 READ: first data nibble (high) driven on the SCK fall after the 2nd dummy rise, then low nibble, alternating; address increments after each low nibble.
REQ-019 WRITE: nibble pairs assembled high then low; byte written on the low-nibble rise; address then increments.
REQ-020 Address SHALL wrap 0xFFFF -> 0x0000 in both READ and WRITE.
REQ-021 cs=1 in any state SHALL return the FSM to IDLE the next cycle, clear the nibble counter and deassert oe; a partial write byte is discarded.
REQ-022 IGNORE: no sampling and no driving until cs=1.
REQ-023 SCK rise and cs deassert in the same cycle: cs wins; no sample, no write.
REQ-024 o_resp_sqi_oe SHALL be 1 only in READ; o_resp_sqi_data SHALL be 0 whenever oe=0.

Reset
REQ-025 Reset values: state IDLE, sck_q 0, cs_q 1, address 0, nibble counter 0, o_resp_sqi_data 0, o_resp_sqi_oe 0.
REQ-026 Reset mid-transaction SHALL abort it immediately; storage contents are not cleared.

Configuration
REQ-027 Macro IDLI_SQI_RESP_WRITE_EN defined: behaviour per REQ-015/019.
REQ-028 Macro IDLI_SQI_RESP_WRITE_EN undefined: instruction 0x02 -> IGNORE; the storage write port is tied off; storage is read-only and preloaded by the bench.

Structure
REQ-029 idli_pkg SHALL hold sqi_resp_state_t, SQI_INSTR_READ=0x03, SQI_INSTR_WRITE=0x02, SQI_ADDR_W=16 and SQI_DUMMY_CYCLES=2.
REQ-030 Storage SHALL be the sub-module idli_sqi_resp_mem_m: 2^SQI_ADDR_W bytes, one synchronous read port and one write port, 1-cycle read latency.

Verification
REQ-031 Bench SHALL cover mem[0x1234]=0xA5 with cs low, instr 0x03, addr 0x1234, 2 dummy cycles -> nibbles 0xA then 0x5 on falls, with oe=1.
REQ-032 Bench SHALL cover instr 0x02, addr 0x0010, data 0x3C,0x7E, cs high, then read 0x0010 -> returns 0x3C,0x7E (WRITE_EN defined).
REQ-033 Bench SHALL cover mem[0xFFFF]=0x11 and mem[0x0000]=0x22 with a read at 0xFFFF of 2 bytes -> 0x11 then 0x22 (wrap).
REQ-034 Bench SHALL cover instr 0x9F -> IGNORE, oe=0 throughout; the next transaction after cs high behaves normally.
REQ-035 Bench SHALL cover a write to 0x0020 with cs raised after the high nibble -> mem[0x0020] unchanged; the FSM is in IDLE one cycle later.
REQ-036 Bench SHALL cover i_resp_rst pulsed during READ -> state IDLE and oe=0 in the same cycle; storage is preserved on re-read.
